writeback_queue: RTL

- Writer-side front end for the 32x64 register file's single write port.
- Accepts writeback requests from two producers (ALU result, memory load) via valid/ready handshakes and buffers them in an in-order FIFO.
- Drains one entry per cycle onto the register file's write_enable/write_addr/write_data.
- Provides two forwarding lookups so decode-stage reads see pending, not-yet-written values.

---
 rtl/writeback_pkg.sv | 15 +
 rtl/wb_fwd_match.sv | 39 +++
 rtl/writeback_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/writeback_pkg.sv
// Shared types and constants for the register-file writeback queue.
// The zero register is never stored and never forwarded.
package writeback_pkg;

    localparam int         WB_DEPTH      = 4;
    localparam int         WB_DATA_WIDTH = 64;
    localparam int         WB_ADDR_WIDTH = 5;
    localparam logic [4:0] ZERO_REG      = 5'd31;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the occupied FIFO slots, oldest (head) to youngest.
// A later match overrides an earlier one, so the result is the most recent pending write.
module wb_fwd_match
    import writeback_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int PTR_W      = $clog2(DEPTH),
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_data,
    input  logic [PTR_W-1:0]                 head,
    input  logic [CNT_W-1:0]                 count,
    input  logic [ADDR_WIDTH-1:0]            lookup_addr,
    output logic                             hit,
    output logic [DATA_WIDTH-1:0]            data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((i < int'(count)) && (entry_addr[idx] == lookup_addr) &&
                (lookup_addr != ZERO_ADDR)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO in front of the register file write port, fed by the ALU
// and load producers, drained one entry per cycle, with two forwarding lookups.
module writeback_queue
    import writeback_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [ADDR_WIDTH-1:0]        alu_addr,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         mem_ready,
    input  logic                         drain_enable,
    output logic                         write_enable,
    output logic [ADDR_WIDTH-1:0]        write_addr,
    output logic [DATA_WIDTH-1:0]        write_data,
    input  logic [ADDR_WIDTH-1:0]        fwd_addr_1,
    input  logic [ADDR_WIDTH-1:0]        fwd_addr_2,
    output logic                         fwd_hit_1,
    output logic                         fwd_hit_2,
    output logic [DATA_WIDTH-1:0]        fwd_data_1,
    output logic [DATA_WIDTH-1:0]        fwd_data_2,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FREE_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] st_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] st_data;
    logic [PTR_W-1:0]                 head;
    logic [PTR_W-1:0]                 tail;
    logic [PTR_W-1:0]                 mem_slot;
    logic [FREE_W-1:0]                free;
    logic                             drain;
    logic                             acc_alu;
    logic                             acc_mem;
    logic                             enq_alu;
    logic                             enq_mem;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign drain = drain_enable & ~empty;

    // A producer transfers on any cycle where valid and ready are both high; ready is
    // computed from occupancy and drain_enable only, so alu_ready never looks at a valid,
    // while mem_ready may look at alu_valid to leave the last free slot to the ALU.
    assign free      = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(drain);
    assign alu_ready = (free != '0);
    assign mem_ready = (free >= FREE_W'(2)) | ((free == FREE_W'(1)) & ~alu_valid);

    assign acc_alu = alu_valid & alu_ready;
    assign acc_mem = mem_valid & mem_ready;
    // Zero-register writes are acknowledged but dropped here.
    assign enq_alu = acc_alu & (alu_addr != ZERO_ADDR);
    assign enq_mem = acc_mem & (mem_addr != ZERO_ADDR);

    // The ALU entry is older, so it takes tail and the load entry lands behind it.
    assign mem_slot = tail + PTR_W'(enq_alu);

    assign write_enable = drain;
    assign write_addr   = st_addr[head];
    assign write_data   = st_data[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count + CNT_W'(enq_alu) + CNT_W'(enq_mem) - CNT_W'(drain);
            head  <= head + PTR_W'(drain);
            tail  <= tail + PTR_W'(enq_alu) + PTR_W'(enq_mem);
        end
    end

    // Storage is not reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (enq_alu) begin
            st_addr[tail] <= alu_addr;
            st_data[tail] <= alu_data;
        end
        if (enq_mem) begin
            st_addr[mem_slot] <= mem_addr;
            st_data[mem_slot] <= mem_data;
        end
    end

    wb_fwd_match #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) u_fwd_1 (
        .entry_addr  (st_addr),
        .entry_data  (st_data),
        .head        (head),
        .count       (count),
        .lookup_addr (fwd_addr_1),
        .hit         (fwd_hit_1),
        .data        (fwd_data_1)
    );

    wb_fwd_match #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) u_fwd_2 (
        .entry_addr  (st_addr),
        .entry_data  (st_data),
        .head        (head),
        .count       (count),
        .lookup_addr (fwd_addr_2),
        .hit         (fwd_hit_2),
        .data        (fwd_data_2)
    );

endmodule
